// File: rtl/time_keeper_if.sv
// Time-of-day control/status bundle between the button/strobe logic
// and the time keeper core.
interface time_keeper_if;
  logic       i_tick;
  logic       i_set_valid;
  logic [7:0] i_set_hh;
  logic [7:0] i_set_mm;
  logic [7:0] i_set_ss;
  logic       i_set_pm;
  logic       i_inc_hr;
  logic       i_inc_min;
  logic [7:0] o_hh;
  logic [7:0] o_mm;
  logic [7:0] o_ss;
  logic       o_pm;
  logic       o_sec;
  logic       o_rollover;
  logic       o_set_ack;
  logic       o_set_err;

  modport master (
    output i_tick, i_set_valid, i_set_hh, i_set_mm,
    output i_set_ss, i_set_pm, i_inc_hr, i_inc_min,
    input  o_hh, o_mm, o_ss, o_pm,
    input  o_sec, o_rollover, o_set_ack, o_set_err
  );

  modport slave (
    input  i_tick, i_set_valid, i_set_hh, i_set_mm,
    input  i_set_ss, i_set_pm, i_inc_hr, i_inc_min,
    output o_hh, o_mm, o_ss, o_pm,
    output o_sec, o_rollover, o_set_ack, o_set_err
  );
endinterface

// File: rtl/time_keeper.sv
// BCD time-of-day counter with prescaler, load and increment controls.
// Define TWELVE_HOUR_EN for a 12-hour clock with AM/PM flag.
module time_keeper #(
    parameter int TICKS_PER_SEC = 1
) (
    input logic         i_clk,
    input logic         i_reset,
    time_keeper_if.slave bus
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

`ifdef TWELVE_HOUR_EN
    localparam logic [7:0] HH_RST = 8'h12;
`else
    localparam logic [7:0] HH_RST = 8'h00;
`endif

    logic [7:0]    hh, mm, ss;
    logic          pm;
    logic [PW-1:0] presc;
    logic          sec, roll, ack, err;

    logic [7:0] hh_nx, mm_nx, ss_nx;
    logic       pm_nx, day_end, ss_end, mm_end;
    logic       set_ok, set_pm_v;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Valid BCD digits compare numerically like plain hex.
    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    always_comb begin
        ss_end = (ss == 8'h59);
        mm_end = (mm == 8'h59);
        ss_nx  = ss_end ? 8'h00 : bcd_inc(ss);
        mm_nx  = mm_end ? 8'h00 : bcd_inc(mm);
`ifdef TWELVE_HOUR_EN
        hh_nx    = (hh == 8'h12) ? 8'h01 : bcd_inc(hh);
        pm_nx    = pm ^ (hh == 8'h11);
        day_end  = (hh == 8'h11) && pm;
        set_pm_v = bus.i_set_pm;
        set_ok   = bcd_ok(bus.i_set_hh, 8'h12) && (bus.i_set_hh != 8'h00);
`else
        hh_nx    = (hh == 8'h23) ? 8'h00 : bcd_inc(hh);
        pm_nx    = 1'b0;
        day_end  = (hh == 8'h23);
        set_pm_v = 1'b0;
        set_ok   = bcd_ok(bus.i_set_hh, 8'h23);
`endif
        set_ok = set_ok && bcd_ok(bus.i_set_mm, 8'h59)
                        && bcd_ok(bus.i_set_ss, 8'h59);
    end

`ifndef TWELVE_HOUR_EN
    logic unused_pm;
    assign unused_pm = bus.i_set_pm;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hh    <= HH_RST;
            mm    <= 8'h00;
            ss    <= 8'h00;
            pm    <= 1'b0;
            presc <= '0;
            sec   <= 1'b0;
            roll  <= 1'b0;
            ack   <= 1'b0;
            err   <= 1'b0;
        end else begin
            sec  <= 1'b0;
            roll <= 1'b0;
            ack  <= 1'b0;
            err  <= 1'b0;
            if (bus.i_set_valid) begin
                if (set_ok) begin
                    hh    <= bus.i_set_hh;
                    mm    <= bus.i_set_mm;
                    ss    <= bus.i_set_ss;
                    pm    <= set_pm_v;
                    presc <= '0;
                    ack   <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end else if (bus.i_inc_hr) begin
                hh    <= hh_nx;
                pm    <= pm_nx;
                presc <= '0;
            end else if (bus.i_inc_min) begin
                mm    <= mm_nx;
                ss    <= 8'h00;
                presc <= '0;
            end else if (bus.i_tick) begin
                if (presc == LAST) begin
                    presc <= '0;
                    sec   <= 1'b1;
                    ss    <= ss_nx;
                    if (ss_end) begin
                        mm <= mm_nx;
                        if (mm_end) begin
                            hh   <= hh_nx;
                            pm   <= pm_nx;
                            roll <= day_end;
                        end
                    end
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

    assign bus.o_hh       = hh;
    assign bus.o_mm       = mm;
    assign bus.o_ss       = ss;
    assign bus.o_pm       = pm;
    assign bus.o_sec      = sec;
    assign bus.o_rollover = roll;
    assign bus.o_set_ack  = ack;
    assign bus.o_set_err  = err;

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: directed vectors plus random traffic checked
// against a seconds-of-day reference model, at 1 and 120 ticks/second.
module tb_time_keeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, tick, set_valid, set_pm, inc_hr, inc_min;
    logic [7:0] set_hh, set_mm, set_ss;

    time_keeper_if if1 ();
    time_keeper_if if120 ();

    assign if1.i_tick        = tick;
    assign if1.i_set_valid   = set_valid;
    assign if1.i_set_hh      = set_hh;
    assign if1.i_set_mm      = set_mm;
    assign if1.i_set_ss      = set_ss;
    assign if1.i_set_pm      = set_pm;
    assign if1.i_inc_hr      = inc_hr;
    assign if1.i_inc_min     = inc_min;
    assign if120.i_tick      = tick;
    assign if120.i_set_valid = set_valid;
    assign if120.i_set_hh    = set_hh;
    assign if120.i_set_mm    = set_mm;
    assign if120.i_set_ss    = set_ss;
    assign if120.i_set_pm    = set_pm;
    assign if120.i_inc_hr    = inc_hr;
    assign if120.i_inc_min   = inc_min;

    time_keeper #(.TICKS_PER_SEC(1)) u1 (
        .i_clk(clk), .i_reset(rst), .bus(if1.slave));
    time_keeper #(.TICKS_PER_SEC(120)) u120 (
        .i_clk(clk), .i_reset(rst), .bus(if120.slave));

    int errors = 0;
    int checks = 0;

    // Reference state: seconds since midnight plus tick count.
    int tod[2];
    int pre[2];
    int tps[2] = '{1, 120};
    logic [28:0] expv[2];

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    function automatic bit bcd_val(input logic [7:0] b, output int v);
        v = int'(b[7:4]) * 10 + int'(b[3:0]);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    function automatic logic [28:0] show(input int t, input bit s,
                                         input bit r, input bit a, input bit e);
        int h, dh;
        bit p;
        h = t / 3600;
`ifdef TWELVE_HOUR_EN
        dh = (h % 12 == 0) ? 12 : h % 12;
        p  = (h >= 12);
`else
        dh = h;
        p  = 1'b0;
`endif
        return {to_bcd(dh), to_bcd((t / 60) % 60), to_bcd(t % 60), p, s, r, a, e};
    endfunction

    task automatic model_step(input int k);
        int h, m, vh, vm, vs, h24;
        bit ok, s, r, a, e;
        s = 0; r = 0; a = 0; e = 0;
        if (rst) begin
            tod[k] = 0;
            pre[k] = 0;
        end else if (set_valid) begin
            ok = bcd_val(set_hh, vh);
            ok = bcd_val(set_mm, vm) && ok;
            ok = bcd_val(set_ss, vs) && ok && vm < 60 && vs < 60;
`ifdef TWELVE_HOUR_EN
            ok  = ok && vh >= 1 && vh <= 12;
            h24 = (vh % 12) + (set_pm ? 12 : 0);
`else
            ok  = ok && vh < 24;
            h24 = vh;
`endif
            if (ok) begin
                tod[k] = h24 * 3600 + vm * 60 + vs;
                pre[k] = 0;
                a = 1;
            end else begin
                e = 1;
            end
        end else if (inc_hr) begin
            h = tod[k] / 3600;
            tod[k] = tod[k] + (((h + 1) % 24) - h) * 3600;
            pre[k] = 0;
        end else if (inc_min) begin
            h = tod[k] / 3600;
            m = (tod[k] / 60) % 60;
            tod[k] = h * 3600 + ((m + 1) % 60) * 60;
            pre[k] = 0;
        end else if (tick) begin
            pre[k]++;
            if (pre[k] == tps[k]) begin
                pre[k] = 0;
                tod[k] = (tod[k] + 1) % 86400;
                s = 1;
                r = (tod[k] == 0);
            end
        end
        expv[k] = show(tod[k], s, r, a, e);
    endtask

    function automatic logic [28:0] act(input int k);
        if (k == 0)
            return {if1.o_hh, if1.o_mm, if1.o_ss, if1.o_pm,
                    if1.o_sec, if1.o_rollover, if1.o_set_ack, if1.o_set_err};
        return {if120.o_hh, if120.o_mm, if120.o_ss, if120.o_pm,
                if120.o_sec, if120.o_rollover, if120.o_set_ack, if120.o_set_err};
    endfunction

    task automatic check(input string name, input logic [28:0] got,
                         input logic [28:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got hh:mm:ss=%h:%h:%h pm/sec/roll/ack/err=%b want %h:%h:%h %b",
                     name, got[28:21], got[20:13], got[12:5], got[4:0],
                     want[28:21], want[20:13], want[12:5], want[4:0]);
        end
    endtask

    task automatic step();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check("model_tps1", act(0), expv[0]);
        check("model_tps120", act(1), expv[1]);
    endtask

    task automatic idle();
        rst = 0; tick = 0; set_valid = 0; set_pm = 0;
        inc_hr = 0; inc_min = 0;
        set_hh = 8'h00; set_mm = 8'h00; set_ss = 8'h00;
    endtask

    task automatic load(input logic [7:0] h, input logic [7:0] m,
                        input logic [7:0] s, input logic p);
        idle();
        set_valid = 1; set_hh = h; set_mm = m; set_ss = s; set_pm = p;
        step();
        idle();
    endtask

    typedef struct {
        bit         r, sv, ih, im, tk;
        logic [7:0] hh, mm, ss;
        logic [28:0] want;
    } vec_t;

    function automatic vec_t mk(input bit r, input bit sv, input logic [7:0] hh,
                                input logic [7:0] mm, input logic [7:0] ss,
                                input bit ih, input bit im, input bit tk,
                                input logic [7:0] eh, input logic [7:0] em,
                                input logic [7:0] es, input logic [4:0] fl);
        vec_t v;
        v.r = r; v.sv = sv; v.hh = hh; v.mm = mm; v.ss = ss;
        v.ih = ih; v.im = im; v.tk = tk;
        v.want = {eh, em, es, fl};
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        logic [7:0] ss0;
        idle();
        rst = 1;
        step();
        idle();

        for (int i = 0; i < 100; i++) begin
            step();
            check("reset_idle", act(0), show(0, 0, 0, 0, 0));
        end

        // 120 ticks spaced 15 cycles: only the 120th advances u120.
        ss0 = if120.o_ss;
        for (int i = 1; i <= 120; i++) begin
            tick = 1;
            step();
            tick = 0;
            if (i == 119)
                check("presc_119", act(1), show(0, 0, 0, 0, 0));
            if (i == 120)
                check("presc_120", act(1), show(1, 1, 0, 0, 0));
            for (int j = 0; j < 14; j++)
                step();
        end
        checks++;
        if (ss0 !== 8'h00) begin
            errors++;
            $display("FAIL presc_start: got %h want 00", ss0);
        end

`ifndef TWELVE_HOUR_EN
        // flags: pm sec roll ack err
        tbl.push_back(mk(1,0,8'h00,8'h00,8'h00,0,0,0, 8'h00,8'h00,8'h00,5'b00000));
        tbl.push_back(mk(0,1,8'h23,8'h59,8'h58,0,0,0, 8'h23,8'h59,8'h58,5'b00010));
        tbl.push_back(mk(0,0,8'h00,8'h00,8'h00,0,0,1, 8'h23,8'h59,8'h59,5'b01000));
        tbl.push_back(mk(0,0,8'h00,8'h00,8'h00,0,0,1, 8'h00,8'h00,8'h00,5'b01100));
        tbl.push_back(mk(0,1,8'h24,8'h00,8'h00,0,0,0, 8'h00,8'h00,8'h00,5'b00001));
        tbl.push_back(mk(0,1,8'h12,8'h5A,8'h00,0,0,0, 8'h00,8'h00,8'h00,5'b00001));
        tbl.push_back(mk(0,1,8'h12,8'h00,8'h60,0,0,0, 8'h00,8'h00,8'h00,5'b00001));
        tbl.push_back(mk(0,1,8'h10,8'h59,8'h30,0,0,0, 8'h10,8'h59,8'h30,5'b00010));
        tbl.push_back(mk(0,0,8'h00,8'h00,8'h00,0,1,0, 8'h10,8'h00,8'h00,5'b00000));
        tbl.push_back(mk(0,1,8'h23,8'h15,8'h42,0,0,0, 8'h23,8'h15,8'h42,5'b00010));
        tbl.push_back(mk(0,0,8'h00,8'h00,8'h00,1,0,0, 8'h00,8'h15,8'h42,5'b00000));
        tbl.push_back(mk(0,0,8'h00,8'h00,8'h00,0,1,1, 8'h00,8'h16,8'h00,5'b00000));
        tbl.push_back(mk(0,0,8'h00,8'h00,8'h00,0,0,0, 8'h00,8'h16,8'h00,5'b00000));
        tbl.push_back(mk(0,0,8'h00,8'h00,8'h00,0,0,1, 8'h00,8'h16,8'h01,5'b01000));
        tbl.push_back(mk(0,1,8'h09,8'h08,8'h07,1,0,1, 8'h09,8'h08,8'h07,5'b00010));
        tbl.push_back(mk(0,1,8'h1A,8'h00,8'h00,0,0,0, 8'h09,8'h08,8'h07,5'b00001));
        tbl.push_back(mk(1,1,8'h05,8'h00,8'h00,0,0,0, 8'h00,8'h00,8'h00,5'b00000));
        foreach (tbl[i]) begin
            idle();
            rst = tbl[i].r; set_valid = tbl[i].sv;
            set_hh = tbl[i].hh; set_mm = tbl[i].mm; set_ss = tbl[i].ss;
            inc_hr = tbl[i].ih; inc_min = tbl[i].im; tick = tbl[i].tk;
            step();
            check($sformatf("vec%0d", i), act(0), tbl[i].want);
        end
        idle();
`else
        idle();
        rst = 1;
        step();
        check("rst12", act(0), {8'h12, 8'h00, 8'h00, 5'b00000});
        load(8'h11, 8'h59, 8'h59, 0);
        tick = 1;
        step();
        check("am_to_pm", act(0), {8'h12, 8'h00, 8'h00, 5'b11000});
        load(8'h11, 8'h59, 8'h59, 1);
        tick = 1;
        step();
        check("pm_to_am", act(0), {8'h12, 8'h00, 8'h00, 5'b01100});
        load(8'h00, 8'h00, 8'h00, 0);
        check("load_h00", act(0), {8'h12, 8'h00, 8'h00, 5'b00001});
        load(8'h13, 8'h00, 8'h00, 0);
        check("load_h13", act(0), {8'h12, 8'h00, 8'h00, 5'b00001});
        load(8'h11, 8'h30, 8'h00, 1);
        inc_hr = 1;
        step();
        check("inchr_pm", act(0), {8'h12, 8'h30, 8'h00, 5'b00000});
        idle();
`endif

        // Random traffic against the reference model.
        for (int i = 0; i < 4000; i++) begin
            idle();
            rst       = ($urandom_range(0, 299) == 0);
            set_valid = ($urandom_range(0, 19) == 0);
            inc_hr    = ($urandom_range(0, 29) == 0);
            inc_min   = ($urandom_range(0, 29) == 0);
            tick      = ($urandom_range(0, 1) == 0);
            set_pm    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) begin
                set_hh = to_bcd($urandom_range(0, 23));
                set_mm = to_bcd($urandom_range(0, 59));
                set_ss = to_bcd($urandom_range(50, 59));
            end else begin
                set_hh = 8'($urandom);
                set_mm = 8'($urandom);
                set_ss = 8'($urandom);
            end
            step();
        end
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
